// File: rtl/mc_path_gen.sv
// Monte Carlo binomial path generator: streams N paths x DAY steps in day-major order,
// each sample = prev price x (up|down factor) picked by a 16-bit Fibonacci LFSR.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; start captures s0/up/down/seed
// EMIT  | path_valid high, one sample retired per accepted handshake
// DONE  | final sample accepted; done pulse, busy drops on exit
module mc_path_gen #(
    parameter int N    = 256,
    parameter int DAY  = 8,
    parameter int W    = 12,
    parameter int FRAC = 10,
    localparam int IW  = (N   > 1) ? $clog2(N)   : 1,
    localparam int DW  = (DAY > 1) ? $clog2(DAY) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [W-1:0]  s0_i,
    input  logic [W-1:0]  up_i,
    input  logic [W-1:0]  down_i,
    input  logic [15:0]   seed_i,
    input  logic          out_ready_i,
    output logic          path_valid_o,
    output logic [W-1:0]  path_o,
    output logic [IW-1:0] path_idx_o,
    output logic [DW-1:0] day_o,
    output logic          day_first_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam logic [15:0] LFSR_INIT = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          valid_q, valid_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;
    logic [W-1:0]  path_q,  path_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [DW-1:0] day_q,   day_d;
    logic [15:0]   lfsr_q,  lfsr_d;
    logic [W-1:0]  s0_q,    s0_d;
    logic [W-1:0]  up_q,    up_d;
    logic [W-1:0]  down_q,  down_d;
    logic [W-1:0]  mem_q [N];
    logic          mem_we;

    logic          accept;
    logic          last_smp;
    logic [IW-1:0] idx_nxt;
    logic [DW-1:0] day_nxt;
    logic [15:0]   lfsr_adv;
    logic [15:0]   seed_eff;
    logic [W-1:0]  prev_nxt;

    // Q(W-FRAC).FRAC multiply, truncate, clamp to full scale.
    function automatic logic [W-1:0] mul_sat(input logic [W-1:0] a, input logic [W-1:0] f);
        logic [2*W-1:0] prod;
        logic [2*W-1:0] shifted;
        prod    = {{W{1'b0}}, a} * {{W{1'b0}}, f};
        shifted = prod >> FRAC;
        if (shifted[2*W-1:W] != '0) begin
            return {W{1'b1}};
        end
        return shifted[W-1:0];
    endfunction

    assign accept   = valid_q && out_ready_i;
    assign last_smp = (idx_q == IW'(N - 1)) && (day_q == DW'(DAY - 1));
    assign idx_nxt  = idx_q + IW'(1);
    assign day_nxt  = (idx_q == IW'(N - 1)) ? day_q + DW'(1) : day_q;
    assign lfsr_adv = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign seed_eff = (seed_i == 16'h0000) ? LFSR_INIT : seed_i;

    // Day 0 always starts from s0; a one-path configuration must bypass the
    // entry being written on this same edge.
    always_comb begin
        prev_nxt = mem_q[idx_nxt];
        if (day_nxt == '0) begin
            prev_nxt = s0_q;
        end else if (idx_nxt == idx_q) begin
            prev_nxt = path_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_EMIT;
            S_EMIT:  if (accept && last_smp) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        path_d  = path_q;
        idx_d   = idx_q;
        day_d   = day_q;
        lfsr_d  = lfsr_q;
        s0_d    = s0_q;
        up_d    = up_q;
        down_d  = down_q;
        mem_we  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    s0_d    = s0_i;
                    up_d    = up_i;
                    down_d  = down_i;
                    lfsr_d  = seed_eff;
                    path_d  = mul_sat(s0_i, seed_eff[0] ? up_i : down_i);
                    idx_d   = '0;
                    day_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_EMIT: begin
                if (accept) begin
                    mem_we = 1'b1;
                    lfsr_d = lfsr_adv;
                    idx_d  = idx_nxt;
                    day_d  = day_nxt;
                    if (last_smp) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        path_d = mul_sat(prev_nxt, lfsr_adv[0] ? up_q : down_q);
                    end
                end
            end
            S_DONE: begin
                busy_d = 1'b0;
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            path_q  <= '0;
            idx_q   <= '0;
            day_q   <= '0;
            lfsr_q  <= LFSR_INIT;
            s0_q    <= '0;
            up_q    <= '0;
            down_q  <= '0;
        end else begin
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            path_q  <= path_d;
            idx_q   <= idx_d;
            day_q   <= day_d;
            lfsr_q  <= lfsr_d;
            s0_q    <= s0_d;
            up_q    <= up_d;
            down_q  <= down_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx_q] <= path_q;
        end
    end

    assign path_valid_o = valid_q;
    assign path_o       = path_q;
    assign path_idx_o   = idx_q;
    assign day_o        = day_q;
    assign day_first_o  = valid_q && (idx_q == '0);
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: doc/mc_path_gen.md
Name: mc_path_gen

Overview:
- Producer side of the Monte Carlo option-pricing datapath. Generates N binomial stock-price paths over DAY time steps and streams one path sample per accepted handshake into the pricing core.
- Each sample is previous price × (up or down factor), selected by an internal LFSR bit.
- Per-path state is held in an internal N-entry register array.
- Emission order is day-major: all N paths for day 0, then all N for day 1, and so on.

Parameters:
- N, 256, number of paths (power of 2).
- DAY, 8, number of time steps (power of 2).
- W, 12, price width (unsigned).
- FRAC, 10, fractional bits of the up/down factors (unsigned Q(W-FRAC).FRAC).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to generate a full path set; sampled only in IDLE.
- s0  in  W  initial price; captured on accepted start.
- up  in  W  up factor, Q2.10; captured on accepted start.
- down  in  W  down factor, Q2.10; captured on accepted start.
- seed  in  16  LFSR seed; captured on accepted start.
- out_ready  in  1  consumer ready.
- path_valid  out  1  sample valid.
- path  out  W  price sample.
- path_idx  out  log2(N)  path index of the current sample.
- day  out  log2(DAY)  time step of the current sample.
- day_first  out  1  high with path_valid when path_idx==0 (start of a day).
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the final sample is accepted.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE.
  - path_valid, busy, done, day_first, path, path_idx, day all 0.
  - LFSR=16'hACE1; memory cleared to 0.
  - Reset mid-run aborts immediately; no further samples; next run needs a new start.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1; shifts left, feedback into bit 0.
  - Loaded with seed on start; a seed of 0 loads 16'hACE1 instead.
  - Advances exactly once per accepted sample.
  - Bit 0 of the current LFSR value selects the factor: 1=up, 0=down.
- Sample arithmetic: prev × factor gives a 2W product, then a logical right shift by FRAC. If the result exceeds 2^W-1 it saturates to 2^W-1. Truncation, no rounding.
  - prev = captured s0 when day==0, else mem[idx].
- FSM states: IDLE, EMIT, DONE.
  - IDLE, start=1:
    - Capture s0, up, down, seed and load the LFSR.
    - Compute sample (idx 0, day 0) from s0 and the loaded LFSR bit 0.
    - Next cycle: path_valid=1, busy=1, state EMIT. Latency start→first valid = 1 cycle.
  - EMIT:
    - Outputs are registered and held stable while path_valid && !out_ready.
    - On accept (path_valid && out_ready):
      - mem[idx] <= path.
      - Advance the LFSR.
      - Increment idx; when idx wraps from N-1 to 0, increment day.
      - Compute the next sample in the same cycle. The next sample reads mem[idx+1], which still holds the previous day's value.
      - path_valid stays 1 (back-to-back, one sample per cycle when out_ready is held high).
    - On accept of (idx N-1, day DAY-1): path_valid <= 0, state DONE.
  - DONE: done=1 for one cycle, busy <= 0, state IDLE.
- start is ignored while busy or in DONE.
- Total accepted samples per run = N×DAY exactly.
- path_valid never drops mid-run except at run end.
- day_first = path_valid && (path_idx==0).

Test Plan:
- Identity: s0=100, up=down=1024, out_ready=1 → N×DAY samples all =100; path_idx 0..N-1 repeating, day 0..DAY-1; done pulses 1 cycle after the last accept; total run = N×DAY+2 cycles from start.
- Growth/saturation: s0=100, up=down=2048 → day d samples = 100·2^(d+1): 200, 400, 800, 1600, 3200; days 5..7 = 4095 (saturated).
- LFSR selection: s0=1000, up=1024, down=512, seed=16'h0001 → sample k matches reference model: 1000 if LFSR bit 0 = 1, else 500 (day 0); later days compound per path.
- Seed zero: seed=0 produces a stream identical to seed=16'hACE1.
- Backpressure: random out_ready (~50%) → path, path_idx, day stable while stalled; no dropped or duplicated samples; sequence identical to the out_ready=1 run.
- Reset/start: assert rst_n=0 mid-day 3 → all outputs 0 next edge; start pulses while busy are ignored; a fresh start after reset reproduces a full correct run.
